uart_dump_seq: RTL
==================

UART_DUMP_SEQ -- requirements
Module: uart_dump_seq

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 4, words printed per output line before CR LF.
REQ-002 SHALL have port clk  input  1  system clock, all flops rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port uart_data  input  32  address word from command decoder.
REQ-005 SHALL have ports read_start_set, read_end_set, read_stop  input  1 each  data-memory dump start-address latch, end-address latch plus launch, and abort.
REQ-006 SHALL have ports pgm_start_set, pgm_end_set, pgm_stop  input  1 each  instruction-memory equivalents of REQ-005.
REQ-007 SHALL have ports pc_print  input  1  PC print launch; pc_value  input  32  current PC.
REQ-008 SHALL have port quit_cmd  input  1  global abort.
REQ-009 SHALL have ports mem_req  output  1; mem_sel  output  1  (0 dmem, 1 imem); mem_addr  output  32; mem_ack  input  1; mem_rdata  input  32, valid when mem_ack=1.
REQ-010 SHALL have ports tx_data  output  8; tx_valid  output  1; tx_ready  input  1  byte stream to UART transmitter.
REQ-011 SHALL have port dump_running  output  1  high while any dump or PC print is active.

Function
REQ-012 SHALL latch uart_data with bits [1:0] forced to 0 into start_addr on read_start_set/pgm_start_set, and into end_addr on read_end_set/pgm_end_set.
REQ-013 SHALL, when idle, launch a dump on read_end_set (mem_sel=0) or pgm_end_set (mem_sel=1); dump_running and mem_req rise the next cycle with mem_addr=start_addr.
REQ-014 SHALL implement states IDLE, MREQ, MWAIT, HEX, SEP, CR, LF, PCHEX.
REQ-015 SHALL hold mem_req high in MREQ until mem_ack; rdata captured on the ack cycle, then HEX; mem_req single-beat, never re-asserted before ack.
REQ-016 SHALL emit each word as 8 lowercase ASCII hex chars, MSB nibble first (0-9 -> 0x30-0x39, a-f -> 0x61-0x66).
REQ-017 SHALL follow each word with space 0x20, or with CR 0x0d then LF 0x0a when WORDS_PER_LINE words are complete on the line or the word is the last.
REQ-018 SHALL hold tx_data stable with tx_valid high until tx_ready; one byte transfers per cycle with tx_valid&tx_ready.
REQ-019 SHALL increment address by 4; last word when addr>=end_addr, so end_addr<=start_addr dumps exactly one word.
REQ-020 SHALL treat addr 0xFFFFFFFC as last word, no wrap to 0.
REQ-021 SHALL, on pc_print when idle, capture pc_value, emit 8 hex chars then CR LF via PCHEX, with dump_running high throughout.
REQ-022 SHALL, on read_stop/pgm_stop/quit_cmd while active, finish any byte already presented (tx_valid high) or outstanding mem_req, then go IDLE without further bytes and without CR LF.
REQ-023 SHALL ignore launch inputs while active; start/end latches still update.
REQ-024 SHALL deassert dump_running the cycle after the final LF handshake or abort completion.
REQ-025 SHALL give abort priority over launch when both occur in the same idle cycle (no launch).

Reset
REQ-026 SHALL reset state IDLE; mem_req, tx_valid, dump_running, mem_sel 0; mem_addr, tx_data, start_addr, end_addr, line counter 0.
REQ-027 SHALL, on rst_n assertion mid-operation, drop all outputs to reset values immediately and produce no further bytes.

Structure
REQ-028 SHALL place state encoding, CR/LF/SP ASCII constants and nibble-to-ASCII function in shared package mon_pkg.
REQ-029 SHALL be a single module, no sub-module; memory and UART TX live outside.

Verification
REQ-030 SHALL test start 0x00000010, end 0x0000001c, dmem words 0x11111111..0x44444444, tx_ready=1 -> "11111111 22222222 33333333 44444444\r\n", 4 mem_req, mem_sel=0.
REQ-031 SHALL test pgm start 0x100, end 0x0f0 -> one imem read at 0x100, 8 hex chars + CR LF, dump_running low after LF.
REQ-032 SHALL test pc_value 0x0000abcd, pc_print -> "0000abcd\r\n", no mem_req.
REQ-033 SHALL test 6-word dump with random tx_ready stalls -> CR LF after word 4 and word 6, tx_data stable while stalled.
REQ-034 SHALL test quit_cmd during 3rd char of word 2 with tx_ready=0 -> that char completes on tx_ready, then IDLE, no CR LF.
REQ-035 SHALL test start 0xFFFFFFF8, end 0xFFFFFFFF -> exactly two reads (0xFFFFFFF8, 0xFFFFFFFC), no address wrap.

Source files
------------

// File: rtl/mon_pkg.sv
// Shared constants and helpers for the memory/PC dump sequencer:
// state encoding, ASCII control characters and nibble-to-hex conversion.
package mon_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MREQ  = 3'd1;
  localparam logic [2:0] S_MWAIT = 3'd2;
  localparam logic [2:0] S_HEX   = 3'd3;
  localparam logic [2:0] S_SEP   = 3'd4;
  localparam logic [2:0] S_CR    = 3'd5;
  localparam logic [2:0] S_LF    = 3'd6;
  localparam logic [2:0] S_PCHEX = 3'd7;

  localparam logic [7:0] ASCII_CR = 8'h0d;
  localparam logic [7:0] ASCII_LF = 8'h0a;
  localparam logic [7:0] ASCII_SP = 8'h20;

  // Highest word-aligned address; always treated as the final word.
  localparam logic [31:0] LAST_ADDR = 32'hFFFF_FFFC;

  // Lowercase ASCII hex digit for one nibble.
  function automatic logic [7:0] nib2asc(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return {4'h3, nib};
    end else begin
      return 8'h57 + {4'h0, nib};
    end
  endfunction

endpackage

// File: rtl/uart_dump_seq_if.sv
// Memory read port and UART byte stream of the dump sequencer, bundled for
// the surrounding system and benches.
interface uart_dump_seq_if (
  input logic clk
);
  logic        mem_req;
  logic        mem_sel;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    input  clk,
    output mem_req, mem_sel, mem_addr,
    input  mem_ack, mem_rdata,
    output tx_data, tx_valid,
    input  tx_ready
  );

  modport slave (
    input  clk,
    input  mem_req, mem_sel, mem_addr,
    output mem_ack, mem_rdata,
    input  tx_data, tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_dump_seq.sv
// Dumps a data/instruction memory range or the current PC as lowercase hex
// over a byte-wide UART stream, WORDS_PER_LINE words per CR LF terminated line.
module uart_dump_seq
  import mon_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] uart_data,
  input  logic        read_start_set,
  input  logic        read_end_set,
  input  logic        read_stop,
  input  logic        pgm_start_set,
  input  logic        pgm_end_set,
  input  logic        pgm_stop,
  input  logic        pc_print,
  input  logic [31:0] pc_value,
  input  logic        quit_cmd,
  output logic        mem_req,
  output logic        mem_sel,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        dump_running
);

  localparam int LCW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  logic [2:0]     state_q, state_d;
  logic [31:0]    start_addr_q, start_addr_d;
  logic [31:0]    end_addr_q, end_addr_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_sel_q, mem_sel_d;
  logic [31:0]    word_q, word_d;
  logic [2:0]     nib_q, nib_d;
  logic [LCW-1:0] line_cnt_q, line_cnt_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_valid_q, tx_valid_d;
  logic           running_q, running_d;
  logic           abort_q, abort_d;
  logic           last_q, last_d;

  logic abort_in_s, abort_s, hs_s, is_last_s, line_full_s, go_idle_s;

  assign abort_in_s  = read_stop | pgm_stop | quit_cmd;
  assign abort_s     = abort_q | abort_in_s;
  assign hs_s        = tx_valid_q & tx_ready;
  assign is_last_s   = (mem_addr_q >= end_addr_q) || (mem_addr_q == LAST_ADDR);
  assign line_full_s = (line_cnt_q == LCW'(WORDS_PER_LINE - 1));

  // Next-state and datapath logic for the dump sequencer.
  always_comb begin
    state_d      = state_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_req_d    = mem_req_q;
    mem_sel_d    = mem_sel_q;
    word_d       = word_q;
    nib_d        = nib_q;
    line_cnt_d   = line_cnt_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    running_d    = running_q;
    abort_d      = abort_q | abort_in_s;
    last_d       = last_q;
    go_idle_s    = 1'b0;

    if (read_start_set || pgm_start_set) begin
      start_addr_d = {uart_data[31:2], 2'b00};
    end else begin
      start_addr_d = start_addr_q;
    end
    if (read_end_set || pgm_end_set) begin
      end_addr_d = {uart_data[31:2], 2'b00};
    end else begin
      end_addr_d = end_addr_q;
    end

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        // An abort arriving with a launch in the same cycle wins.
        if (abort_in_s) begin
          state_d = S_IDLE;
        end else if (read_end_set || pgm_end_set) begin
          state_d    = S_MREQ;
          mem_req_d  = 1'b1;
          mem_sel_d  = ~read_end_set;
          mem_addr_d = start_addr_q;
          running_d  = 1'b1;
          line_cnt_d = '0;
          last_d     = 1'b0;
        end else if (pc_print) begin
          state_d    = S_PCHEX;
          word_d     = pc_value;
          tx_data_d  = nib2asc(pc_value[31:28]);
          tx_valid_d = 1'b1;
          nib_d      = 3'd0;
          running_d  = 1'b1;
          last_d     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MREQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          word_d    = mem_rdata;
          last_d    = is_last_s;
          if (abort_s) begin
            go_idle_s = 1'b1;
          end else begin
            state_d = S_MWAIT;
          end
        end else begin
          state_d = S_MREQ;
        end
      end
      S_MWAIT: begin
        if (abort_s) begin
          go_idle_s = 1'b1;
        end else begin
          state_d    = S_HEX;
          tx_data_d  = nib2asc(word_q[31:28]);
          tx_valid_d = 1'b1;
          nib_d      = 3'd0;
        end
      end
      S_HEX, S_PCHEX: begin
        if (!hs_s) begin
          state_d = state_q;
        end else if (abort_s) begin
          go_idle_s = 1'b1;
        end else if (nib_q != 3'd7) begin
          word_d    = {word_q[27:0], 4'h0};
          tx_data_d = nib2asc(word_q[27:24]);
          nib_d     = nib_q + 3'd1;
        end else if (state_q == S_PCHEX || last_q || line_full_s) begin
          state_d    = S_CR;
          tx_data_d  = ASCII_CR;
          line_cnt_d = '0;
        end else begin
          state_d    = S_SEP;
          tx_data_d  = ASCII_SP;
          line_cnt_d = line_cnt_q + LCW'(1);
        end
      end
      S_CR: begin
        if (!hs_s) begin
          state_d = S_CR;
        end else if (abort_s) begin
          go_idle_s = 1'b1;
        end else begin
          state_d   = S_LF;
          tx_data_d = ASCII_LF;
        end
      end
      S_SEP, S_LF: begin
        // Leaving a line end on the final word completes the dump; otherwise fetch the next word.
        if (!hs_s) begin
          state_d = state_q;
        end else if (abort_s || (state_q == S_LF && last_q)) begin
          go_idle_s = 1'b1;
        end else begin
          state_d    = S_MREQ;
          tx_valid_d = 1'b0;
          mem_req_d  = 1'b1;
          mem_addr_d = mem_addr_q + 32'd4;
        end
      end
      default: begin
        go_idle_s = 1'b1;
      end
    endcase

    if (go_idle_s) begin
      state_d    = S_IDLE;
      tx_valid_d = 1'b0;
      mem_req_d  = 1'b0;
      running_d  = 1'b0;
      abort_d    = 1'b0;
    end else begin
      running_d = running_d;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_addr_q <= 32'd0;
      end_addr_q   <= 32'd0;
      mem_addr_q   <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_sel_q    <= 1'b0;
      word_q       <= 32'd0;
      nib_q        <= 3'd0;
      line_cnt_q   <= '0;
      tx_data_q    <= 8'd0;
      tx_valid_q   <= 1'b0;
      running_q    <= 1'b0;
      abort_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      mem_sel_q    <= mem_sel_d;
      word_q       <= word_d;
      nib_q        <= nib_d;
      line_cnt_q   <= line_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      running_q    <= running_d;
      abort_q      <= abort_d;
      last_q       <= last_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_sel      = mem_sel_q;
  assign mem_addr     = mem_addr_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign dump_running = running_q;

endmodule
